// File: rtl/eth_egress_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_egress_sched                                             |
// | Description : Packet-granular weighted arbiter between the CHDR (x2e) and  |
// |               CPU (c2e) streams in front of the Ethernet MAC. CHDR wins by |
// |               default; CPU is granted after CHDR_WEIGHT CHDR packets have  |
// |               passed while it waited. Registered 64-bit AXIS output.       |
// |               Optional packet statistics: ETH_EGRESS_SCHED_STATS_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eth_egress_sched #(
    parameter int CHDR_WEIGHT = 4,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] s_chdr_tdata,
    input  logic [3:0]  s_chdr_tuser,
    input  logic        s_chdr_tlast,
    input  logic        s_chdr_tvalid,
    output logic        s_chdr_tready,
    input  logic [63:0] s_cpu_tdata,
    input  logic [3:0]  s_cpu_tuser,
    input  logic        s_cpu_tlast,
    input  logic        s_cpu_tvalid,
    output logic        s_cpu_tready,
    output logic [63:0] m_mac_tdata,
    output logic [3:0]  m_mac_tuser,
    output logic        m_mac_tlast,
    output logic        m_mac_tvalid,
    input  logic        m_mac_tready,
    output logic        busy,
    input  logic        stats_clear,
    output logic [31:0] stat_chdr_pkts,
    output logic [31:0] stat_cpu_pkts
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GNT_CHDR = 2'd1,
        S_GNT_CPU  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_WEIGHT = CNT_W'(CHDR_WEIGHT);

    state_t           r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_mac_tvalid;
    logic [63:0]      r_mac_tdata;
    logic [3:0]       r_mac_tuser;
    logic             r_mac_tlast;

    logic        w_out_free;
    logic        w_chdr_acc;
    logic        w_cpu_acc;
    logic        w_acc;
    logic        w_chdr_end;
    logic        w_cpu_end;
    logic [63:0] w_in_tdata;
    logic [3:0]  w_in_tuser;
    logic        w_in_tlast;

    // The output register can take a new beat whenever it is empty or draining.
    assign w_out_free    = !r_mac_tvalid || m_mac_tready;
    assign s_chdr_tready = (r_state == S_GNT_CHDR) && w_out_free;
    assign s_cpu_tready  = (r_state == S_GNT_CPU)  && w_out_free;

    assign w_chdr_acc = s_chdr_tready && s_chdr_tvalid;
    assign w_cpu_acc  = s_cpu_tready  && s_cpu_tvalid;
    assign w_acc      = w_chdr_acc || w_cpu_acc;
    assign w_chdr_end = w_chdr_acc && s_chdr_tlast;
    assign w_cpu_end  = w_cpu_acc  && s_cpu_tlast;

    assign w_in_tdata = (r_state == S_GNT_CPU) ? s_cpu_tdata : s_chdr_tdata;
    assign w_in_tuser = (r_state == S_GNT_CPU) ? s_cpu_tuser : s_chdr_tuser;
    assign w_in_tlast = (r_state == S_GNT_CPU) ? s_cpu_tlast : s_chdr_tlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_mac_tvalid <= 1'b0;
            r_mac_tdata  <= '0;
            r_mac_tuser  <= '0;
            r_mac_tlast  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_chdr_tvalid && s_cpu_tvalid) begin
                        r_state <= (r_starve_cnt >= C_WEIGHT) ? S_GNT_CPU : S_GNT_CHDR;
                    end else if (s_chdr_tvalid) begin
                        r_state <= S_GNT_CHDR;
                    end else if (s_cpu_tvalid) begin
                        r_state <= S_GNT_CPU;
                    end
                end
                S_GNT_CHDR: begin
                    if (w_chdr_end) begin
                        r_state <= S_IDLE;
                        // Only CHDR packets that overtook a waiting CPU packet count.
                        if (s_cpu_tvalid && (r_starve_cnt < C_WEIGHT)) begin
                            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                        end
                    end
                end
                S_GNT_CPU: begin
                    if (w_cpu_end) begin
                        r_state      <= S_IDLE;
                        r_starve_cnt <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_acc) begin
                r_mac_tvalid <= 1'b1;
                r_mac_tdata  <= w_in_tdata;
                r_mac_tuser  <= w_in_tuser;
                r_mac_tlast  <= w_in_tlast;
            end else if (m_mac_tready) begin
                r_mac_tvalid <= 1'b0;
            end
        end
    end

    assign m_mac_tvalid = r_mac_tvalid;
    assign m_mac_tdata  = r_mac_tdata;
    assign m_mac_tuser  = r_mac_tuser;
    assign m_mac_tlast  = r_mac_tlast;
    assign busy         = (r_state != S_IDLE) || r_mac_tvalid;

`ifdef ETH_EGRESS_SCHED_STATS_EN
    logic [31:0] r_stat_chdr;
    logic [31:0] r_stat_cpu;

    // Clear outranks a coincident packet end.
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clear) begin
            r_stat_chdr <= '0;
            r_stat_cpu  <= '0;
        end else begin
            if (w_chdr_end) begin
                r_stat_chdr <= r_stat_chdr + 32'd1;
            end
            if (w_cpu_end) begin
                r_stat_cpu <= r_stat_cpu + 32'd1;
            end
        end
    end

    assign stat_chdr_pkts = r_stat_chdr;
    assign stat_cpu_pkts  = r_stat_cpu;
`else
    logic w_unused_stats_clear;
    assign w_unused_stats_clear = stats_clear;
    assign stat_chdr_pkts       = '0;
    assign stat_cpu_pkts        = '0;
`endif

endmodule
`default_nettype wire
